// File: rtl/exotiny_clkrst_if.sv
// rtl/exotiny_clkrst_if.sv - control and status bundle of the clock-enable / reset sequencer
interface exotiny_clkrst_if #(
  parameter int DIV_W = 4,
  parameter int N_RST = 2
);
  logic             locked_i;
  logic             soft_rst_i;
  logic [DIV_W-1:0] div_i;
  logic             div_load_i;
  logic             clk_en_o;
  logic             clk_div_o;
  logic [N_RST-1:0] rst_n_o;
  logic             ready_o;
  logic [7:0]       lock_loss_cnt_o;

  modport slave (
    input  locked_i, soft_rst_i, div_i, div_load_i,
    output clk_en_o, clk_div_o, rst_n_o, ready_o, lock_loss_cnt_o
  );

  modport master (
    output locked_i, soft_rst_i, div_i, div_load_i,
    input  clk_en_o, clk_div_o, rst_n_o, ready_o, lock_loss_cnt_o
  );
endinterface

// File: rtl/exotiny_clkrst.sv
// rtl/exotiny_clkrst.sv - programmable clock-enable divider, lock monitor and staged reset release
module exotiny_clkrst #(
  parameter int DIV_W     = 4,
  parameter int DIV_RST   = 15,
  parameter int DLY_W     = 8,
  parameter int N_RST     = 2,
  parameter int STAGE_GAP = 4
) (
  input  logic            clk_i,
  input  logic            rst_in,
  exotiny_clkrst_if.slave bus
);

  localparam int GAP_W = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam int STG_W = 4;
  localparam logic [DLY_W-1:0] DLY_LAST = '1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(STAGE_GAP - 1);
  localparam logic [STG_W-1:0] STG_LAST = STG_W'(N_RST - 1);

  typedef enum logic [1:0] {HOLD, DELAY, RELEASE, RUN} state_t;

  logic sync_q, locked_s;

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      sync_q   <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync_q   <= bus.locked_i;
      locked_s <= sync_q;
    end
  end

  logic [DIV_W-1:0] div_r, cnt;
  logic             clk_en_q, clk_div_q;

  // A load restarts the period and wins over a wrap in the same cycle.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      div_r     <= DIV_W'(DIV_RST);
      cnt       <= '0;
      clk_en_q  <= 1'b0;
      clk_div_q <= 1'b0;
    end else if (bus.div_load_i) begin
      div_r    <= bus.div_i;
      cnt      <= '0;
      clk_en_q <= 1'b0;
    end else if (cnt == div_r) begin
      cnt       <= '0;
      clk_en_q  <= 1'b1;
      clk_div_q <= ~clk_div_q;
    end else begin
      cnt      <= cnt + 1'b1;
      clk_en_q <= 1'b0;
    end
  end

  state_t           state_q, state_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [STG_W-1:0] stage_q, stage_d;
  logic [N_RST-1:0] rst_n_q, rst_n_d;
  logic             ready_q, ready_d;
  logic [7:0]       loss_q, loss_d;
  logic             abort;
  logic [N_RST-1:0] rst_n_shift;

  // Releases are strictly ordered, so the next released bit is a 1 shifted in at the bottom.
  assign rst_n_shift = N_RST'({rst_n_q, 1'b1});

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= HOLD;
      dly_q   <= '0;
      gap_q   <= '0;
      stage_q <= '0;
      rst_n_q <= '0;
      ready_q <= 1'b0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      gap_q   <= gap_d;
      stage_q <= stage_d;
      rst_n_q <= rst_n_d;
      ready_q <= ready_d;
      loss_q  <= loss_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    gap_d   = gap_q;
    stage_d = stage_q;
    rst_n_d = rst_n_q;
    ready_d = ready_q;
    loss_d  = loss_q;
    abort   = (state_q != HOLD) && (!locked_s || bus.soft_rst_i);
    if (abort) begin
      state_d = HOLD;
      dly_d   = '0;
      gap_d   = '0;
      stage_d = '0;
      rst_n_d = '0;
      ready_d = 1'b0;
      // Lock loss takes precedence when both causes coincide.
      if (!locked_s && loss_q != 8'hFF) loss_d = loss_q + 8'd1;
    end else begin
      case (state_q)
        HOLD: begin
          if (locked_s && !bus.soft_rst_i) begin
            state_d = DELAY;
            dly_d   = '0;
          end
        end
        DELAY: begin
          dly_d = dly_q + 1'b1;
          if (dly_q == DLY_LAST) begin
            dly_d   = '0;
            rst_n_d = rst_n_shift;
            gap_d   = '0;
            stage_d = STG_W'(1);
            if (N_RST == 1) begin
              state_d = RUN;
              ready_d = 1'b1;
            end else begin
              state_d = RELEASE;
            end
          end
        end
        RELEASE: begin
          gap_d = gap_q + 1'b1;
          if (gap_q == GAP_LAST) begin
            gap_d   = '0;
            rst_n_d = rst_n_shift;
            stage_d = stage_q + 1'b1;
            if (stage_q == STG_LAST) begin
              state_d = RUN;
              ready_d = 1'b1;
            end
          end
        end
        RUN:     state_d = RUN;
        default: state_d = HOLD;
      endcase
    end
  end

  assign bus.clk_en_o        = clk_en_q;
  assign bus.clk_div_o       = clk_div_q;
  assign bus.rst_n_o         = rst_n_q;
  assign bus.ready_o         = ready_q;
  assign bus.lock_loss_cnt_o = loss_q;

endmodule

// File: tb/tb_exotiny_clkrst.sv
// tb/tb_exotiny_clkrst.sv - scoreboard bench for the clock-enable / reset sequencer
module tb_exotiny_clkrst;
  localparam int DIV_W = 4, DIV_RST = 15, DLY_W = 3, N_RST = 3, STAGE_GAP = 2;
  localparam int S_RSTN = 0, S_READY = 1, S_LOSS = 2, S_EN = 3, S_DIV = 4;

  typedef struct {
    int cyc;
    int sel;
    int val;
  } exp_t;

  logic clk_i  = 1'b0;
  logic rst_in = 1'b0;
  int   cyc    = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  exotiny_clkrst_if #(.DIV_W(DIV_W), .N_RST(N_RST)) bus ();

  exotiny_clkrst #(
    .DIV_W(DIV_W), .DIV_RST(DIV_RST), .DLY_W(DLY_W), .N_RST(N_RST), .STAGE_GAP(STAGE_GAP)
  ) dut (
    .clk_i (clk_i),
    .rst_in(rst_in),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_checks++;
    if (obs !== 32'(exp)) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sample(input int sel);
    case (sel)
      S_RSTN:  return 32'(bus.rst_n_o);
      S_READY: return 32'(bus.ready_o);
      S_LOSS:  return 32'(bus.lock_loss_cnt_o);
      S_EN:    return 32'(bus.clk_en_o);
      default: return 32'(bus.clk_div_o);
    endcase
  endfunction

  function automatic string sel_name(input int sel);
    case (sel)
      S_RSTN:  return "rst_n";
      S_READY: return "ready";
      S_LOSS:  return "loss_cnt";
      S_EN:    return "clk_en";
      default: return "clk_div";
    endcase
  endfunction

  always @(negedge clk_i) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        chk($sformatf("%s@%0d", sel_name(sb[i].sel), cyc), sample(sb[i].sel), sb[i].val);
        sb.delete(i);
      end
    end
  end

  task automatic push(input int c, input int sel, input int val);
    exp_t e;
    e.cyc = c;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  // Lock seen before edge e: releases at e+10 and e+12 with DLY_W=3, STAGE_GAP=2.
  task automatic push_seq(input int e);
    push(e + 9,  S_RSTN, 0);
    push(e + 10, S_RSTN, 1);
    push(e + 11, S_RSTN, 1);
    push(e + 12, S_RSTN, 3);
  endtask

  task automatic push_done(input int e);
    push(e + 13, S_READY, 0);
    push(e + 14, S_RSTN, 7);
    push(e + 14, S_READY, 1);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  int r, c, f, g, t, x, exp_cnt, exp_nxt;

  initial begin
    bus.locked_i   = 1'b0;
    bus.soft_rst_i = 1'b0;
    bus.div_i      = '0;
    bus.div_load_i = 1'b0;
    step(3);
    chk("rst_rst_n", 32'(bus.rst_n_o), 0);
    chk("rst_ready", 32'(bus.ready_o), 0);
    chk("rst_clk_en", 32'(bus.clk_en_o), 0);
    chk("rst_clk_div", 32'(bus.clk_div_o), 0);
    chk("rst_loss", 32'(bus.lock_loss_cnt_o), 0);

    // power-up sequence and default divider
    rst_in = 1'b1;
    bus.locked_i = 1'b1;
    r = cyc;
    push_seq(r + 1);
    push_done(r + 1);
    push(r + 15, S_LOSS, 0);
    push(r + 15, S_EN, 0);
    push(r + 16, S_EN, 1);
    push(r + 17, S_EN, 0);
    push(r + 16, S_DIV, 1);
    push(r + 31, S_DIV, 1);
    push(r + 32, S_EN, 1);
    push(r + 32, S_DIV, 0);
    step(40);

    // load 2 mid-period, then load 0 on a wrap edge
    c = cyc;
    push(c + 1, S_EN, 0);
    push(c + 3, S_EN, 0);
    push(c + 4, S_EN, 1);
    push(c + 5, S_EN, 0);
    push(c + 7, S_EN, 1);
    push(c + 9, S_EN, 0);
    push(c + 10, S_EN, 0);
    push(c + 11, S_EN, 1);
    push(c + 14, S_EN, 1);
    bus.div_i = 4'd2;
    bus.div_load_i = 1'b1;
    step(1);
    bus.div_load_i = 1'b0;
    step(8);
    bus.div_i = 4'd0;
    bus.div_load_i = 1'b1;
    step(1);
    bus.div_load_i = 1'b0;
    step(10);

    // lock loss in RUN, then full restart
    f = cyc;
    push(f + 2, S_RSTN, 7);
    push(f + 2, S_READY, 1);
    push(f + 2, S_LOSS, 0);
    push(f + 3, S_RSTN, 0);
    push(f + 3, S_READY, 0);
    push(f + 3, S_LOSS, 1);
    bus.locked_i = 1'b0;
    step(4);
    g = cyc;
    bus.locked_i = 1'b1;
    push_seq(g + 1);
    step(13);

    // soft reset while rst_n_o=011, held for 5 cycles
    t = g + 14;
    push(t, S_RSTN, 0);
    push(t, S_READY, 0);
    push(t, S_LOSS, 1);
    push(t + 4, S_RSTN, 0);
    push_seq(t + 3);
    push_done(t + 3);
    bus.soft_rst_i = 1'b1;
    step(5);
    bus.soft_rst_i = 1'b0;
    step(16);

    // lock loss coincident with soft reset counts once
    x = cyc;
    push(x + 2, S_RSTN, 7);
    push(x + 3, S_RSTN, 0);
    push(x + 3, S_LOSS, 2);
    push(x + 5, S_LOSS, 2);
    bus.locked_i = 1'b0;
    step(2);
    bus.soft_rst_i = 1'b1;
    step(1);
    bus.soft_rst_i = 1'b0;
    step(4);

    // 260 lock losses out of DELAY
    exp_cnt = 2;
    for (int i = 0; i < 260; i++) begin
      x = cyc;
      exp_nxt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      push(x + 5, S_LOSS, exp_cnt);
      push(x + 6, S_LOSS, exp_nxt);
      exp_cnt = exp_nxt;
      bus.locked_i = 1'b1;
      step(3);
      bus.locked_i = 1'b0;
      step(4);
    end
    push(cyc + 15, S_LOSS, 255);
    step(20);

    // asynchronous reset during DELAY
    bus.locked_i = 1'b1;
    step(4);
    #3;
    rst_in = 1'b0;
    #1;
    chk("async_rst_n", 32'(bus.rst_n_o), 0);
    chk("async_ready", 32'(bus.ready_o), 0);
    chk("async_clk_en", 32'(bus.clk_en_o), 0);
    chk("async_clk_div", 32'(bus.clk_div_o), 0);
    chk("async_loss", 32'(bus.lock_loss_cnt_o), 0);
    @(posedge clk_i);
    #1;
    rst_in = 1'b1;
    r = cyc;
    push_seq(r + 1);
    push_done(r + 1);
    push(r + 1, S_LOSS, 0);
    push(r + 15, S_EN, 0);
    push(r + 16, S_EN, 1);
    step(20);

    for (int k = 0; k < 50 && sb.size() > 0; k++) step(1);
    chk("sb_left", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/exotiny_clkrst.md
# exotiny_clkrst

Parametrised clock-enable and reset-sequencing controller for ExoTiny FPGA/ASIC top levels. It sits between the PLL (or pad clock) and the core. It replaces the ad-hoc ripple divider and single lock-delay reset with four functions:
- a runtime-programmable clock-enable divider;
- a synchronised lock monitor;
- N staged, ordered reset releases;
- a saturating lock-loss counter readable for debug.

## Interface
Parameters:
- DIV_W, 4: width of divide register and divider counter.
- DIV_RST, 15: divide value after reset; enable period is DIV_RST+1 cycles.
- DLY_W, 8: lock-stable delay is 2^DLY_W clk_i cycles.
- N_RST, 2: number of sequenced reset outputs, 1..8.
- STAGE_GAP, 4: clk_i cycles between successive releases, ≥1.

Ports:
- clk_i  in  1  system clock (single clock domain).
- rst_in  in  1  asynchronous, active-low reset; clears all state.
- locked_i  in  1  PLL lock, asynchronous to clk_i; 2-flop synchronised internally (locked_s).
- soft_rst_i  in  1  synchronous, active-high request to re-run the reset sequence.
- div_i  in  DIV_W  new divide value.
- div_load_i  in  1  loads div_i into div_r.
- clk_en_o  out  1  one-cycle enable pulse, period div_r+1.
- clk_div_o  out  1  toggles with every clk_en_o pulse, period 2·(div_r+1).
- rst_n_o  out  N_RST  active-low domain resets; bit 0 is released first.
- ready_o  out  1  high in RUN (all domains released).
- lock_loss_cnt_o  out  8  saturating count of lock losses.

## Operation
- Reset values, all registered outputs: rst_n_o=0, ready_o=0, clk_en_o=0, clk_div_o=0, lock_loss_cnt_o=0. Internal: div_r=DIV_RST, divider cnt=0, sync flops=0, FSM=HOLD.
- Divider is independent of the FSM and is cleared only by rst_in.
  - Each cycle: if cnt==div_r then cnt←0, clk_en_o←1, clk_div_o toggles; else cnt←cnt+1, clk_en_o←0.
  - div_r=0: clk_en_o stays 1 continuously from the first edge on; clk_div_o toggles every cycle.
  - div_load_i=1: div_r←div_i, cnt←0, clk_en_o←0, clk_div_o holds. The load takes priority over a wrap in the same cycle.
- FSM states are HOLD, DELAY, RELEASE and RUN.
  - HOLD: rst_n_o=0, ready_o=0. If locked_s=1 and soft_rst_i=0, go to DELAY with dly←0.
  - DELAY: dly increments each cycle. When dly==2^DLY_W−1: go to RELEASE, rst_n_o[0]←1, gap←0, stage←1. If N_RST=1, go directly to RUN with ready_o←1.
  - RELEASE: gap increments each cycle. When gap==STAGE_GAP−1: rst_n_o[stage]←1, gap←0, stage←stage+1. Releasing bit N_RST−1 moves to RUN with ready_o←1 on the same edge.
  - RUN: hold outputs.
- Abort, in any state other than HOLD:
  - Trigger: locked_s=0 or soft_rst_i=1.
  - Next edge: go to HOLD, rst_n_o←0 (all bits together), ready_o←0, counters cleared.
- Lock-loss counting:
  - lock_loss_cnt_o increments by 1 on an abort caused by locked_s=0. It saturates at 255.
  - If lock loss and soft_rst_i occur together, the event is counted as a lock loss.
  - soft_rst_i alone does not count.
  - Lock low while in HOLD does not count.
- Released bits never deassert individually. Assertion is always all-bits-at-once.

## Timing
- Synchroniser latency is 2 cycles. locked_i high before edge E gives locked_s=1 after E+1, and HOLD→DELAY at E+2.
- rst_n_o[0] releases at E+2+2^DLY_W. Bit k releases at E+2+2^DLY_W+k·STAGE_GAP. ready_o rises with the last bit.
- Abort latency:
  - soft_rst_i sampled at edge T gives rst_n_o=0 after T.
  - locked_i falling before edge E gives rst_n_o=0 after E+2.
- soft_rst_i held high keeps the FSM in HOLD. The sequence restarts on the first cycle after it drops, provided locked_s=1.
- rst_in asserted mid-sequence clears everything immediately, without waiting for a clock edge.

## Test plan
Parameters for all scenarios unless stated: DLY_W=3, N_RST=3, STAGE_GAP=2, DIV_W=4, DIV_RST=15.
- Power-up: release rst_in, raise locked_i before edge E → rst_n_o=001 at E+10, 011 at E+12, 111 with ready_o=1 at E+14.
- Divider: after reset, clk_en_o pulses every 16 cycles and clk_div_o has a period of 32. Load div_i=2 mid-period → cnt restarts at 0, first pulse 3 cycles later, then every 3. Load div_i=0 → clk_en_o stays 1.
- Lock loss in RUN: drop locked_i before edge E → rst_n_o=000 and ready_o=0 after E+2, lock_loss_cnt_o=1. Re-raise locked_i → full sequence repeats with identical timing.
- Abort mid-RELEASE: assert soft_rst_i when rst_n_o=011 → 000 next edge, counter unchanged. Hold soft_rst_i for 5 cycles → no release until it drops.
- Saturation and simultaneity: 260 lock losses → lock_loss_cnt_o=255. Lock loss coincident with soft_rst_i → counted once.
- Async reset: assert rst_in during DELAY between edges → all outputs 0 immediately, div_r=15.
